count_event_monitor: RTL and testbench
======================================

Name: count_event_monitor

Overview:
- Sits directly downstream of the 5-bit ripple carry counter and samples its count output `q` every clock.
- Classifies each sample-to-sample step as hold, increment, wrap, restart or fault.
- Keeps a saturating wrap tally and queues typed event records in a small FIFO, drained by a valid/ready consumer.
- Lets the lab observe counter sequencing on-chip instead of through simulator monitor output.

Parameters:
- WIDTH, 5, counter width; matches counter `q`.
- FIFO_DEPTH, 4, event FIFO entries; power of 2, ≥2.
- WRAP_W, 8, width of wrap tally.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- q_in  in  WIDTH  counter output sample.
- match_val  in  WIDTH  count value that raises a match event.
- clear  in  1  synchronous soft clear.
- evt_ready  in  1  consumer accepts head record.
- evt_valid  out  1  FIFO non-empty.
- evt_data  out  WIDTH+2  head record: {type[1:0], value[WIDTH-1:0]}. Type encoding: 00 match, 01 wrap, 10 restart, 11 fault.
- wrap_count  out  WRAP_W  number of wraps (MAX→0) seen.
- fault  out  1  sticky; illegal step detected.
- overflow  out  1  sticky; event dropped because FIFO was full.

Behaviour:
- Definitions: MAX = 2^WIDTH−1. `prev` = the q_in value registered at the previous edge.
- Reset values: all outputs 0, FIFO empty, FSM = SYNC, prev = 0.
- FSM states: SYNC, TRACK, FAULT.
- SYNC: load prev ← q_in; no event; go to TRACK next edge.
- TRACK: each edge, classify q_in against prev:
  - hold (q_in == prev): no event.
  - increment (q_in == prev+1, prev ≠ MAX): match event if q_in == match_val.
  - wrap (prev == MAX, q_in == 0): wrap_count += 1, saturating at 2^WRAP_W−1; wrap event, value 0.
  - restart (q_in == 0, prev ∉ {0, MAX}): restart event, value = prev. This covers the counter being reset mid-count.
  - anything else: fault event (value = q_in), fault ← 1, go to FAULT.
  - prev ← q_in every TRACK edge.
- Same-cycle priority: at most one record per cycle, fault > restart > wrap > match. A wrap to 0 with match_val = 0 records wrap only.
- FAULT: no classification, no events, wrap_count frozen, prev not updated. Leave only via clear or reset.
- clear (edge where clear = 1):
  - overrides classification in that cycle;
  - FSM → SYNC, wrap_count ← 0, fault ← 0, overflow ← 0;
  - FIFO flushed; a pop requested in the same cycle is ignored.
- FIFO:
  - first-word fall-through: evt_valid = !empty, evt_data = head whenever evt_valid.
  - Push at the detecting edge; evt_valid rises 1 cycle after the q_in sample that caused the event.
  - Pop when evt_valid && evt_ready at an edge.
  - Full with a push and a pop in the same cycle: both happen; no drop.
  - Full with a push and no pop: record dropped, overflow ← 1.
  - Empty with a push: evt_valid next cycle; a pop cannot bypass.
  - Pointer wrap is modulo FIFO_DEPTH; occupancy counter is 0..FIFO_DEPTH.
  - evt_data is stable while evt_valid && !evt_ready.
- Reset asserted mid-operation: immediate asynchronous return to reset values, including FIFO contents lost.

Test Plan:
- Reset 15 ns, then counter runs 0→31→0 (clk period 10 ns), match_val = 31, evt_ready = 1 → one match record {00, 31}, then one wrap record {01, 0}; wrap_count = 1; fault = 0.
- Counter reaches 17, counter reset asserted so q_in = 0 and held 3 cycles → exactly one restart record {10, 17}; holds produce no events.
- Step q_in from 6 to 9 → fault record {11, 9}, fault = 1; further steps produce no records; after a 1-cycle clear, fault = 0 and wrap_count = 0; sequence 0,1,2 produces no fault.
- evt_ready = 0, force 5 wraps → 4 records buffered, evt_valid = 1, overflow = 1, wrap_count = 5. Then evt_ready = 1 → 4 wrap records popped on consecutive cycles, evt_valid falls.
- FIFO full; the cycle that pushes a new wrap also pops (evt_ready = 1) → no drop, overflow stays 0, occupancy stays 4.
- 300 wraps with evt_ready = 1 → wrap_count saturates at 255. Async reset pulse mid-clock → all outputs 0 immediately, before the next edge.

Source files
------------

// File: rtl/count_event_monitor.sv
// Watches a free-running counter's output, classifies every step and queues typed
// event records (match/wrap/restart/fault) in a small fall-through FIFO.
module count_event_monitor #(
   parameter int WIDTH      = 5,
   parameter int FIFO_DEPTH = 4,
   parameter int WRAP_W     = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  q_in,
   input  logic [WIDTH-1:0]  match_val,
   input  logic              clear,
   input  logic              evt_ready,
   output logic              evt_valid,
   output logic [WIDTH+1:0]  evt_data,
   output logic [WRAP_W-1:0] wrap_count,
   output logic              fault,
   output logic              overflow
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [WIDTH-1:0] MAX      = '1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_SYNC, S_TRACK, S_FAULT} state_t;

   state_t            state_p0, state_nx;
   logic [WIDTH-1:0]  prev_p0;
   logic [WIDTH-1:0]  prev_inc;
   logic              load_prev, push, wrap_hit, fault_hit;
   logic [WIDTH+1:0]  rec;

   logic [WIDTH+1:0]  mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              full, do_push, do_pop;

   function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
      return (v == {WRAP_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   assign prev_inc = prev_p0 + 1'b1;

   // Step classification; the branches are mutually exclusive, so at most one record per cycle.
   always_comb begin
      state_nx  = state_p0;
      load_prev = 1'b0;
      push      = 1'b0;
      wrap_hit  = 1'b0;
      fault_hit = 1'b0;
      rec       = '0;
      case (state_p0)
         S_SYNC: begin
            load_prev = 1'b1;
            state_nx  = S_TRACK;
         end
         S_TRACK: begin
            load_prev = 1'b1;
            if (q_in != prev_p0) begin
               if (prev_p0 != MAX && q_in == prev_inc) begin
                  if (q_in == match_val) begin
                     push = 1'b1;
                     rec  = {2'b00, q_in};
                  end
               end else if (prev_p0 == MAX && q_in == '0) begin
                  wrap_hit = 1'b1;
                  push     = 1'b1;
                  rec      = {2'b01, {WIDTH{1'b0}}};
               end else if (q_in == '0 && prev_p0 != '0) begin
                  push = 1'b1;
                  rec  = {2'b10, prev_p0};
               end else begin
                  fault_hit = 1'b1;
                  push      = 1'b1;
                  rec       = {2'b11, q_in};
                  state_nx  = S_FAULT;
               end
            end
         end
         default: state_nx = S_FAULT;
      endcase
   end

   assign full      = (count == FULL_CNT);
   assign evt_valid = (count != '0);
   assign evt_data  = evt_valid ? mem[rd_ptr] : '0;
   assign do_pop    = evt_valid && evt_ready;
   // A pop frees the slot in the same edge, so a full FIFO still accepts the push.
   assign do_push   = push && (!full || do_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_p0   <= S_SYNC;
         prev_p0    <= '0;
         wrap_count <= '0;
         fault      <= 1'b0;
         overflow   <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
      end else if (clear) begin
         state_p0   <= S_SYNC;
         wrap_count <= '0;
         fault      <= 1'b0;
         overflow   <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
      end else begin
         state_p0 <= state_nx;
         if (load_prev) prev_p0 <= q_in;
         if (wrap_hit) wrap_count <= sat_inc(wrap_count);
         if (fault_hit) fault <= 1'b1;
         if (push && !do_push) overflow <= 1'b1;
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop) count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && !clear && do_push) mem[wr_ptr] <= rec;
   end

endmodule

// File: tb/tb_count_event_monitor.sv
// Directed bench for count_event_monitor: counter sequences, restarts, faults,
// FIFO backpressure/overflow, wrap saturation and asynchronous reset.
module tb_count_event_monitor;

   localparam int WIDTH = 5;

   logic       clk;
   logic       reset;
   logic [4:0] q_in;
   logic [4:0] match_val;
   logic       clear;
   logic       evt_ready;
   logic       evt_valid;
   logic [6:0] evt_data;
   logic [7:0] wrap_count;
   logic       fault;
   logic       overflow;

   int total = 0;
   int bad   = 0;
   int cur   = 0;

   count_event_monitor #(.WIDTH(5), .FIFO_DEPTH(4), .WRAP_W(8)) dut (
      .clk(clk), .reset(reset), .q_in(q_in), .match_val(match_val), .clear(clear),
      .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_data(evt_data),
      .wrap_count(wrap_count), .fault(fault), .overflow(overflow)
   );

   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input int v);
      q_in = 5'(v);
      tick();
      cur = v;
   endtask

   task automatic wrap_once();
      for (int v = cur + 1; v <= 31; v++) step(v);
      step(0);
   endtask

   initial begin
      reset = 1'b1; q_in = '0; match_val = 5'd31; clear = 1'b0; evt_ready = 1'b1;
      #15;
      chk("rst_valid", evt_valid, 0);
      chk("rst_data", evt_data, 0);
      chk("rst_wrap", wrap_count, 0);
      chk("rst_fault", fault, 0);
      chk("rst_ovf", overflow, 0);
      reset = 1'b0;
      tick();
      cur = 0;

      // full count with match on 31, then wrap
      for (int v = 1; v <= 30; v++) step(v);
      chk("no_early_evt", evt_valid, 0);
      step(31);
      chk("match_valid", evt_valid, 1);
      chk("match_data", evt_data, 7'h1F);
      step(0);
      chk("wrap_valid", evt_valid, 1);
      chk("wrap_data", evt_data, 7'h20);
      chk("wrap_cnt1", wrap_count, 1);
      chk("wrap_nofault", fault, 0);
      step(0);
      chk("drained1", evt_valid, 0);

      // counter restarted at 17
      for (int v = 1; v <= 17; v++) step(v);
      chk("pre_restart", evt_valid, 0);
      step(0);
      chk("restart_valid", evt_valid, 1);
      chk("restart_data", evt_data, 7'h51);
      step(0);
      chk("hold1", evt_valid, 0);
      step(0);
      chk("hold2", evt_valid, 0);
      chk("restart_wrap", wrap_count, 1);

      // illegal jump 6 -> 9
      for (int v = 1; v <= 6; v++) step(v);
      step(9);
      chk("fault_valid", evt_valid, 1);
      chk("fault_data", evt_data, 7'h69);
      chk("fault_flag", fault, 1);
      step(10);
      chk("fault_quiet1", evt_valid, 0);
      step(11);
      chk("fault_quiet2", evt_valid, 0);
      chk("fault_sticky", fault, 1);
      clear = 1'b1;
      step(0);
      clear = 1'b0;
      chk("clr_fault", fault, 0);
      chk("clr_wrap", wrap_count, 0);
      chk("clr_valid", evt_valid, 0);
      step(0);
      step(1);
      step(2);
      chk("post_clr_fault", fault, 0);
      chk("post_clr_valid", evt_valid, 0);

      // five wraps with no consumer: four buffered, one dropped
      match_val = 5'd0;
      evt_ready = 1'b0;
      repeat (5) wrap_once();
      chk("bp_valid", evt_valid, 1);
      chk("bp_ovf", overflow, 1);
      chk("bp_wrap", wrap_count, 5);
      chk("bp_data", evt_data, 7'h20);
      evt_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_data", evt_data, 7'h20);
         step(0);
         chk("drain_valid", evt_valid, (i < 3) ? 1 : 0);
      end
      chk("ovf_sticky", overflow, 1);

      // full FIFO with simultaneous push and pop
      clear = 1'b1;
      step(0);
      clear = 1'b0;
      chk("clr2_ovf", overflow, 0);
      chk("clr2_wrap", wrap_count, 0);
      step(0);
      evt_ready = 1'b0;
      repeat (4) wrap_once();
      chk("full_valid", evt_valid, 1);
      chk("full_ovf", overflow, 0);
      for (int v = 1; v <= 31; v++) step(v);
      evt_ready = 1'b1;
      step(0);
      evt_ready = 1'b0;
      chk("pp_ovf", overflow, 0);
      chk("pp_wrap", wrap_count, 5);
      chk("pp_valid", evt_valid, 1);
      evt_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(0);
         chk("pp_occ", evt_valid, (i < 3) ? 1 : 0);
      end

      // saturation, then asynchronous reset between edges
      repeat (300) wrap_once();
      chk("sat_wrap", wrap_count, 255);
      chk("sat_ovf", overflow, 0);
      chk("sat_valid", evt_valid, 1);
      #2 reset = 1'b1;
      #1;
      chk("arst_valid", evt_valid, 0);
      chk("arst_data", evt_data, 0);
      chk("arst_wrap", wrap_count, 0);
      chk("arst_fault", fault, 0);
      chk("arst_ovf", overflow, 0);
      #2 reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
